// File: rtl/highlight_core_if.sv
// FIFO-side bundle for highlight_core: pedestrian and mask show-ahead read
// ports plus the output FIFO write port.
interface highlight_core_if #(
   parameter int PIX = 24
) ();
   logic           ped_empty;
   logic           ped_rd_en;
   logic [PIX-1:0] ped_dout;
   logic           mask_empty;
   logic           mask_rd_en;
   logic [PIX-1:0] mask_dout;
   logic           out_full;
   logic           out_wr_en;
   logic [PIX-1:0] out_din;

   // Combiner side: pops both input FIFOs, pushes the output FIFO.
   modport master (
      input  ped_empty, ped_dout, mask_empty, mask_dout, out_full,
      output ped_rd_en, mask_rd_en, out_wr_en, out_din
   );

   // FIFO side.
   modport slave (
      output ped_empty, ped_dout, mask_empty, mask_dout, out_full,
      input  ped_rd_en, mask_rd_en, out_wr_en, out_din
   );
endinterface

// File: rtl/highlight_core.sv
// Streaming pixel combiner: pops one pedestrian and one mask pixel per pair,
// applies the frame's latched highlight mode, and writes one result pixel
// through a single-entry output register. Frame sequencing is
// IDLE -> RUN -> FLUSH -> DONE.
module highlight_core #(
   parameter  int WIDTH     = 768,
   parameter  int HEIGHT    = 576,
   parameter  int CHANNELS  = 3,
   parameter  int CH_BITS   = 8,
   parameter  int HL_CH     = 2,
   parameter  int DIM_SHIFT = 2,
   localparam int CNT_W     = $clog2(WIDTH*HEIGHT+1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [CH_BITS-1:0] threshold,
   highlight_core_if.master   fifo,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   pixel_count
);
   localparam int PIX = CHANNELS*CH_BITS;
   localparam logic [CNT_W-1:0] TOTAL = CNT_W'(WIDTH*HEIGHT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [1:0] MODE_CUT  = 2'd0;
   localparam logic [1:0] MODE_TINT = 2'd1;
   localparam logic [1:0] MODE_DIM  = 2'd2;

   logic [1:0]         state;
   logic [1:0]         mode_q;
   logic [CH_BITS-1:0] thr_q;
   logic [PIX-1:0]     out_q;
   logic               valid;
   logic               pop;
   logic               wr;
   logic               mask_on;
   logic [PIX-1:0]     result;

   // Handshake: the register may refill in the same cycle it drains.
   always_comb begin
      wr  = valid && !fifo.out_full;
      pop = (state == S_RUN) && (pixel_count < TOTAL) &&
            !fifo.ped_empty && !fifo.mask_empty && (!valid || wr);
   end

   assign fifo.ped_rd_en  = pop;
   assign fifo.mask_rd_en = pop;
   assign fifo.out_wr_en  = wr;
   assign fifo.out_din    = out_q;
   assign busy            = (state != S_IDLE);
   assign done            = (state == S_DONE);

   // Per-pixel highlight function on the FIFO heads.
   always_comb begin
      mask_on = (fifo.mask_dout[CH_BITS-1:0] >= thr_q);
      result  = fifo.ped_dout;
      case (mode_q)
         MODE_CUT:  if (!mask_on) result = '0;
         MODE_TINT: if (mask_on) result[HL_CH*CH_BITS +: CH_BITS] = '1;
         MODE_DIM: begin
            if (!mask_on) begin
               for (int unsigned c = 0; c < CHANNELS; c++)
                  result[c*CH_BITS +: CH_BITS] = fifo.ped_dout[c*CH_BITS +: CH_BITS] >> DIM_SHIFT;
            end
         end
         default: ;
      endcase
   end

   // Frame sequencing, configuration latch and pixel counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         mode_q      <= '0;
         thr_q       <= '0;
         pixel_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q      <= mode;
                  thr_q       <= threshold;
                  pixel_count <= '0;
                  state       <= S_RUN;
               end
            end
            S_RUN: begin
               if (pop) pixel_count <= pixel_count + 1'b1;
               if (pixel_count == TOTAL) state <= S_FLUSH;
            end
            S_FLUSH: if (!valid) state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Single-entry result register; holds while the output FIFO is full.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_q <= '0;
         valid <= 1'b0;
      end else if (pop) begin
         out_q <= result;
         valid <= 1'b1;
      end else if (wr) begin
         valid <= 1'b0;
      end
   end
endmodule
